// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Port 0 is instruction fetch, port 1 is load/store.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    CAPTURE
  } state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 9;

endpackage

// File: rtl/mem_arb_picker.sv
// Grant selection between fetch and load/store ports.
// MEM_ARB_ROUND_ROBIN_EN: alternate on contention; otherwise the data port always wins.
module mem_arb_picker
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic clock,
  input  logic clear,
  input  logic update,
`endif
  input  logic p0_req,
  input  logic p1_req,
  output logic grant
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant;

  // Starts at the data port so the first contention is given to fetch.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      last_grant <= PORT_DATA;
    end else if (update) begin
      last_grant <= grant;
    end
  end

  always_comb begin
    grant = PORT_FETCH;
    if (p0_req && p1_req) begin
      grant = ~last_grant;
    end else if (p1_req) begin
      grant = PORT_DATA;
    end
  end
`else
  always_comb begin
    grant = (p1_req || !p0_req) ? PORT_DATA : PORT_FETCH;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port controller for the single-port main memory: setup, one-cycle strobe, capture.
// Arbitration policy selected by MEM_ARB_ROUND_ROBIN_EN (undefined: data port has priority).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  p0_req,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  output logic                  p0_ack,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_ack,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  mem_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  busy
);

  state_t                state_reg, state_next;
  logic                  grant_reg, grant_next;
  logic                  we_reg, we_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic                  pick;
  logic                  take;
  logic                  capture;

  assign take    = (state_reg == IDLE) && (p0_req || p1_req);
  assign capture = (state_reg == CAPTURE);
  assign busy    = (state_reg != IDLE);

  mem_arb_picker u_picker (
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .clock  (clock),
    .clear  (clear),
    .update (take),
`endif
    .p0_req (p0_req),
    .p1_req (p1_req),
    .grant  (pick)
  );

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    case (state_reg)
      IDLE: begin
        if (take) begin
          state_next = SETUP;
          grant_next = pick;
          if (pick == PORT_DATA) begin
            we_next    = p1_we;
            addr_next  = p1_addr;
            wdata_next = p1_wdata;
          end else begin
            we_next    = 1'b0;
            addr_next  = p0_addr;
            wdata_next = '0;
          end
        end
      end
      SETUP:   state_next = STROBE;
      STROBE:  state_next = CAPTURE;
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Memory-side outputs are registered from the next-state view so they
  // change on the same edge the FSM enters the corresponding phase.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_reg   <= IDLE;
      grant_reg   <= 1'b0;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_enable  <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      p0_ack      <= 1'b0;
      p1_ack      <= 1'b0;
      p0_rdata    <= '0;
      p1_rdata    <= '0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      we_reg      <= we_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      mem_enable  <= (state_next == STROBE);
      mem_read    <= (state_next != IDLE) && !we_next;
      mem_write   <= (state_next != IDLE) && we_next;
      mem_address <= addr_next;
      mem_data_in <= wdata_next;
      p0_ack      <= capture && (grant_reg == PORT_FETCH);
      p1_ack      <= capture && (grant_reg == PORT_DATA);
      if (capture && (grant_reg == PORT_FETCH)) begin
        p0_rdata <= mem_data_out;
      end
      if (capture && (grant_reg == PORT_DATA) && !we_reg) begin
        p1_rdata <= mem_data_out;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: transaction-level model predicts grant order,
// ack cycle and read data; a monitor compares every strobe and ack against it.
module tb_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 9;

  logic          clock = 1'b0;
  logic          clear;
  logic          p0_req, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p1_wdata;
  logic          p0_ack, p1_ack;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          mem_read, mem_write, mem_enable, busy;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in, mem_data_out;

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock        (clock),
    .clear        (clear),
    .p0_req       (p0_req),
    .p0_addr      (p0_addr),
    .p0_ack       (p0_ack),
    .p0_rdata     (p0_rdata),
    .p1_req       (p1_req),
    .p1_we        (p1_we),
    .p1_addr      (p1_addr),
    .p1_wdata     (p1_wdata),
    .p1_ack       (p1_ack),
    .p1_rdata     (p1_rdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_enable   (mem_enable),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural single-port memory: acts on the rising edge of its strobe.
  logic [DW-1:0] sram [512];
  initial begin
    for (int i = 0; i < 512; i++) sram[i] = '0;
    mem_data_out = '0;
  end
  always @(posedge mem_enable) begin
    if (mem_write) sram[mem_address] <= mem_data_in;
    else if (mem_read) mem_data_out <= sram[mem_address];
  end

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  typedef struct {
    int            port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic [DW-1:0] other_rdata;
    int            ack_cyc;
  } exp_t;

  txn_t drv_q0[$];
  txn_t drv_q1[$];
  exp_t exp_q[$];

  logic [DW-1:0] ref_mem [512];
  logic [DW-1:0] last_rd [2];
  int            ref_last_grant = 1;

  int errors = 0;
  int checks = 0;
  bit monitor_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Transaction-level model: every pending request is presented continuously,
  // each access occupies four cycles and is acked three cycles after its grant edge.
  task automatic plan(input int n);
    txn_t q0[$];
    txn_t q1[$];
    txn_t t;
    exp_t e;
    int   s;
    int   g;
    q0 = drv_q0;
    q1 = drv_q1;
    s  = n + 1;
    while (q0.size() > 0 || q1.size() > 0) begin
      if (q0.size() > 0 && q1.size() > 0) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        g = 1 - ref_last_grant;
`else
        g = 1;
`endif
      end else begin
        g = (q1.size() > 0) ? 1 : 0;
      end
      ref_last_grant = g;
      if (g == 1) t = q1.pop_front();
      else begin
        t = q0.pop_front();
        t.we = 1'b0;
      end
      e.port    = g;
      e.we      = t.we;
      e.addr    = t.addr;
      e.wdata   = t.data;
      e.ack_cyc = s + 3;
      if (t.we) ref_mem[t.addr] = t.data;
      else last_rd[g] = ref_mem[t.addr];
      e.rdata       = last_rd[g];
      e.other_rdata = last_rd[1 - g];
      exp_q.push_back(e);
      s += 4;
    end
  endtask

  task automatic apply_heads();
    p0_req = (drv_q0.size() > 0);
    if (drv_q0.size() > 0) p0_addr = drv_q0[0].addr;
    p1_req = (drv_q1.size() > 0);
    if (drv_q1.size() > 0) begin
      p1_we    = drv_q1[0].we;
      p1_addr  = drv_q1[0].addr;
      p1_wdata = drv_q1[0].data;
    end
  endtask

  // Called at a negedge with the arbiter idle; returns at the negedge of the last ack.
  task automatic run_scenario();
    int limit;
    limit = cyc + 4 * (drv_q0.size() + drv_q1.size()) + 12;
    plan(cyc);
    apply_heads();
    while (drv_q0.size() > 0 || drv_q1.size() > 0) begin
      @(negedge clock);
      if (cyc > limit) begin
        fail_now("ack_timeout");
        drv_q0.delete();
        drv_q1.delete();
        exp_q.delete();
        apply_heads();
        break;
      end
      if (p0_ack && drv_q0.size() > 0) void'(drv_q0.pop_front());
      if (p1_ack && drv_q1.size() > 0) void'(drv_q1.pop_front());
      apply_heads();
    end
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    int   k;
    k = $urandom_range(0, 6);
    t.we = 1'($urandom_range(0, 1));
    case (k)
      0:       t.addr = '0;
      1:       t.addr = '1;
      2, 3, 4: t.addr = AW'(k);
      default: t.addr = AW'($urandom_range(0, 511));
    endcase
    t.data = $urandom;
    return t;
  endfunction

  // Monitor: compares each strobe and each ack against the head of the scoreboard.
  int   en_cnt = 0;
  exp_t mon_e;
  always @(negedge clock) begin
    if (monitor_on) begin
      if (mem_enable) begin
        en_cnt++;
        check("busy_in_strobe", busy, 1);
        if (exp_q.size() == 0) fail_now("strobe_unexpected");
        else begin
          check("strobe_addr", mem_address, exp_q[0].addr);
          check("strobe_cmd", {mem_read, mem_write}, {!exp_q[0].we, exp_q[0].we});
          if (exp_q[0].we) check("strobe_wdata", mem_data_in, exp_q[0].wdata);
        end
      end
      if (p0_ack && p1_ack) fail_now("both_acks");
      if (p0_ack || p1_ack) begin
        if (exp_q.size() == 0) fail_now("ack_unexpected");
        else begin
          mon_e = exp_q.pop_front();
          check("ack_port", p1_ack ? 1 : 0, mon_e.port);
          check("ack_cycle", cyc, mon_e.ack_cyc);
          check("enable_pulses", en_cnt, 1);
          check("busy_at_ack", busy, 0);
          if (mon_e.port == 1) begin
            check("p1_rdata", p1_rdata, mon_e.rdata);
            check("p0_rdata_held", p0_rdata, mon_e.other_rdata);
          end else begin
            check("p0_rdata", p0_rdata, mon_e.rdata);
            check("p1_rdata_held", p1_rdata, mon_e.other_rdata);
          end
          $display("ack port=%0d we=%0b addr=%0h cycle=%0d p0_rdata=%0h p1_rdata=%0h",
                   mon_e.port, mon_e.we, mon_e.addr, cyc, p0_rdata, p1_rdata);
        end
        en_cnt = 0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    for (int i = 0; i < 512; i++) ref_mem[i] = '0;
    last_rd[0] = '0;
    last_rd[1] = '0;
    clear = 1'b1; p0_req = 0; p1_req = 0; p1_we = 0;
    p0_addr = '0; p1_addr = '0; p1_wdata = '0;
    repeat (3) @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_acks", {p0_ack, p1_ack}, 0);
    check("rst_rdata", {p0_rdata, p1_rdata}, 0);
    check("rst_cmd", {mem_read, mem_write, mem_enable}, 0);
    check("rst_addr", mem_address, 0);
    check("rst_wdata", mem_data_in, 0);

    // Clear during the strobe of a write: enable drops immediately, access abandoned.
    p1_req = 1; p1_we = 1; p1_addr = 9'h0AA; p1_wdata = 32'hCAFEF00D;
    for (int i = 0; i < 8 && !mem_enable; i++) @(negedge clock);
    check("strobe_reached", mem_enable, 1);
    #2 clear = 1'b1;
    #1;
    check("clr_enable", mem_enable, 0);
    check("clr_busy", busy, 0);
    check("clr_cmd", {mem_read, mem_write}, 0);
    check("clr_addr", mem_address, 0);
    check("clr_wdata", mem_data_in, 0);
    check("clr_acks", {p0_ack, p1_ack}, 0);
    p1_req = 0; p1_we = 0;
    @(negedge clock);
    clear = 1'b0;
    ref_mem[9'h0AA] = 32'hCAFEF00D;
    repeat (2) @(negedge clock);
    check("post_clr_busy", busy, 0);
    check("post_clr_enable", mem_enable, 0);
    $display("reset test done at cycle %0d", cyc);
    monitor_on = 1'b1;

    // Directed: write/read 0x1FF, fetch from 0x000, confirm the abandoned write landed.
    drv_q1.push_back('{we: 1'b1, addr: 9'h1FF, data: 32'hDEADBEEF}); run_scenario();
    drv_q1.push_back('{we: 1'b0, addr: 9'h1FF, data: 32'h0});        run_scenario();
    drv_q1.push_back('{we: 1'b1, addr: 9'h000, data: 32'h12345678}); run_scenario();
    drv_q0.push_back('{we: 1'b0, addr: 9'h000, data: 32'h0});        run_scenario();
    drv_q0.push_back('{we: 1'b0, addr: 9'h0AA, data: 32'h0});        run_scenario();

    // Contention: one request each, then two held back-to-back per port.
    drv_q0.push_back('{we: 1'b0, addr: 9'h1FF, data: 32'h0});
    drv_q1.push_back('{we: 1'b1, addr: 9'h1FF, data: 32'hA5A5A5A5});
    run_scenario();
    drv_q0.push_back('{we: 1'b0, addr: 9'h000, data: 32'h0});
    drv_q0.push_back('{we: 1'b0, addr: 9'h1FF, data: 32'h0});
    drv_q1.push_back('{we: 1'b1, addr: 9'h000, data: 32'h0BADCAFE});
    drv_q1.push_back('{we: 1'b0, addr: 9'h000, data: 32'h0});
    run_scenario();

    // Late arrival: fetch request rises while a data access is in its strobe.
    drv_q1.push_back('{we: 1'b1, addr: 9'h003, data: 32'h55AA55AA});
    plan(cyc);
    apply_heads();
    @(negedge clock);
    @(negedge clock);
    check("late_strobe", mem_enable, 1);
    p0_req = 1; p0_addr = 9'h003;
    @(negedge clock);
    check("late_hold_addr", mem_address, 9'h003);
    check("late_hold_cmd", {mem_read, mem_write}, 2'b01);
    @(negedge clock);
    check("late_p1_ack", p1_ack, 1);
    void'(drv_q1.pop_front());
    p1_req = 0;
    drv_q0.push_back('{we: 1'b0, addr: 9'h003, data: 32'h0});
    run_scenario();

    // Randomized scenarios.
    for (int it = 0; it < 40; it++) begin
      int n0;
      int n1;
      n0 = $urandom_range(0, 2);
      n1 = $urandom_range(0, 2);
      if (n0 == 0 && n1 == 0) n1 = 1;
      for (int j = 0; j < n0; j++) begin
        t = rand_txn();
        t.we = 1'b0;
        drv_q0.push_back(t);
      end
      for (int j = 0; j < n1; j++) drv_q1.push_back(rand_txn());
      run_scenario();
    end

    repeat (6) @(negedge clock);
    check("scoreboard_empty", exp_q.size(), 0);
    check("final_idle", busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
